// File: rtl/amber_mem_ldst.sv
// amber_mem_ldst: memory-access back end of the amber pipeline.
// An MA register captures the EX record, the MO register presents it to WB,
// and a 24-bit word data memory sits between them. Stores write at the edge
// after MA capture. Loads read synchronously into rdata_q at that same edge.
// The opcode encodings are parameters so that the integrating design can pass
// in its own opcode table.
module amber_mem_ldst #(
    parameter int                 MEM_WORDS = 4096,
    parameter int                 OPC_W     = 8,
    parameter int                 TGT_W     = 4,
    parameter logic [OPC_W-1:0]   OPC_NOP   = 8'h00,
    parameter logic [OPC_W-1:0]   OPC_LDur  = 8'h30,
    parameter logic [OPC_W-1:0]   OPC_LDso  = 8'h31,
    parameter logic [OPC_W-1:0]   OPC_STur  = 8'h38,
    parameter logic [OPC_W-1:0]   OPC_STui  = 8'h39,
    parameter logic [OPC_W-1:0]   OPC_STsi  = 8'h3A,
    parameter logic [OPC_W-1:0]   OPC_STso  = 8'h3B
) (
    input  logic              iw_clk,
    input  logic              iw_rst,
    input  logic [47:0]       iw_pc,
    input  logic [23:0]       iw_instr,
    input  logic [OPC_W-1:0]  iw_opc,
    input  logic [47:0]       iw_addr,
    input  logic [23:0]       iw_result,
    input  logic [47:0]       iw_sr_result,
    input  logic [47:0]       iw_ar_result,
    input  logic [TGT_W-1:0]  iw_tgt_gp,
    input  logic [TGT_W-1:0]  iw_tgt_sr,
    input  logic [TGT_W-1:0]  iw_tgt_ar,
    input  logic              iw_tgt_gp_we,
    input  logic              iw_tgt_sr_we,
    input  logic              iw_tgt_ar_we,
    output logic [47:0]       ow_pc,
    output logic [23:0]       ow_instr,
    output logic [OPC_W-1:0]  ow_opc,
    output logic [23:0]       ow_result,
    output logic [47:0]       ow_sr_result,
    output logic [47:0]       ow_ar_result,
    output logic [TGT_W-1:0]  ow_tgt_gp,
    output logic [TGT_W-1:0]  ow_tgt_sr,
    output logic [TGT_W-1:0]  ow_tgt_ar,
    output logic              ow_tgt_gp_we,
    output logic              ow_tgt_sr_we,
    output logic              ow_tgt_ar_we
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    // Pipeline record carried from MA to MO. The memory address is kept
    // beside it because only the MA stage needs it.
    typedef struct packed {
        logic [47:0]      pc;
        logic [23:0]      instr;
        logic [OPC_W-1:0] opc;
        logic [23:0]      result;
        logic [47:0]      sr_result;
        logic [47:0]      ar_result;
        logic [TGT_W-1:0] tgt_gp;
        logic [TGT_W-1:0] tgt_sr;
        logic [TGT_W-1:0] tgt_ar;
        logic             gp_we;
        logic             sr_we;
        logic             ar_we;
    } rec_t;

    function automatic logic is_load(input logic [OPC_W-1:0] opc);
        return (opc == OPC_LDur) || (opc == OPC_LDso);
    endfunction

    function automatic logic is_store(input logic [OPC_W-1:0] opc);
        return (opc == OPC_STur) || (opc == OPC_STui) ||
               (opc == OPC_STsi) || (opc == OPC_STso);
    endfunction

    rec_t             ma_d;
    rec_t             ma_q;
    rec_t             mo_d;
    rec_t             mo_q;
    logic [47:0]      ma_addr_q;
    logic [23:0]      rdata_q;
    logic [AW-1:0]    mem_idx;
    logic             mem_we;
    logic             mem_is48;

    logic [23:0]      r_mem [0:MEM_WORDS-1];

    // Next MA record is the EX record as presented; next MO record is MA.
    always_comb begin
        ma_d           = '0;
        ma_d.pc        = iw_pc;
        ma_d.instr     = iw_instr;
        ma_d.opc       = iw_opc;
        ma_d.result    = iw_result;
        ma_d.sr_result = iw_sr_result;
        ma_d.ar_result = iw_ar_result;
        ma_d.tgt_gp    = iw_tgt_gp;
        ma_d.tgt_sr    = iw_tgt_sr;
        ma_d.tgt_ar    = iw_tgt_ar;
        ma_d.gp_we     = iw_tgt_gp_we;
        ma_d.sr_we     = iw_tgt_sr_we;
        ma_d.ar_we     = iw_tgt_ar_we;
        mo_d           = ma_q;
    end

    // MA and MO pipeline registers; reset leaves a NOP bubble in both.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            ma_q      <= '0;
            ma_q.opc  <= OPC_NOP;
            mo_q      <= '0;
            mo_q.opc  <= OPC_NOP;
            ma_addr_q <= '0;
        end else begin
            ma_q      <= ma_d;
            mo_q      <= mo_d;
            ma_addr_q <= iw_addr;
        end
    end

    // Wide accesses are never issued from here, so the width select is fixed.
    assign mem_is48 = 1'b0;
    assign mem_idx  = AW'(ma_addr_q % 48'(MEM_WORDS));
    assign mem_we   = is_store(ma_q.opc) && !mem_is48 && !iw_rst;

    // Memory write port: store data goes in exactly as EX formed it.
    always_ff @(posedge iw_clk) begin
        if (mem_we) begin
            r_mem[mem_idx] <= ma_q.result;
        end
    end

    // Registered read port. It samples the pre-write word, so a read and a
    // write to the same word on one edge return the old contents.
    always_ff @(posedge iw_clk) begin
        if (iw_rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= r_mem[mem_idx];
        end
    end

    // WB record: loads substitute the memory word for the EX result.
    always_comb begin
        ow_pc        = mo_q.pc;
        ow_instr     = mo_q.instr;
        ow_opc       = mo_q.opc;
        ow_result    = is_load(mo_q.opc) ? rdata_q : mo_q.result;
        ow_sr_result = mo_q.sr_result;
        ow_ar_result = mo_q.ar_result;
        ow_tgt_gp    = mo_q.tgt_gp;
        ow_tgt_sr    = mo_q.tgt_sr;
        ow_tgt_ar    = mo_q.tgt_ar;
        ow_tgt_gp_we = mo_q.gp_we;
        ow_tgt_sr_we = mo_q.sr_we;
        ow_tgt_ar_we = mo_q.ar_we;
    end

endmodule

// File: tb/tb_amber_mem_ldst.sv
// Bench for amber_mem_ldst: directed cases plus a randomized stream.
// The reference model applies transactions in program order to a word array
// and expects each record at WB two edges after it was presented.
module tb_amber_mem_ldst;

    localparam int         MEM_WORDS = 4096;
    localparam logic [7:0] NOP  = 8'h00;
    localparam logic [7:0] LDUR = 8'h30;
    localparam logic [7:0] LDSO = 8'h31;
    localparam logic [7:0] STUR = 8'h38;
    localparam logic [7:0] STUI = 8'h39;
    localparam logic [7:0] STSI = 8'h3A;
    localparam logic [7:0] STSO = 8'h3B;

    typedef struct packed {
        logic [47:0] pc;
        logic [23:0] instr;
        logic [7:0]  opc;
        logic [47:0] addr;
        logic [23:0] result;
        logic [47:0] sr;
        logic [47:0] ar;
        logic [3:0]  tgp;
        logic [3:0]  tsr;
        logic [3:0]  tar;
        logic [2:0]  we;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] iw_pc, iw_addr, iw_sr_result, iw_ar_result;
    logic [23:0] iw_instr, iw_result;
    logic [7:0]  iw_opc;
    logic [3:0]  iw_tgt_gp, iw_tgt_sr, iw_tgt_ar;
    logic        iw_tgt_gp_we, iw_tgt_sr_we, iw_tgt_ar_we;
    logic [47:0] ow_pc, ow_sr_result, ow_ar_result;
    logic [23:0] ow_instr, ow_result;
    logic [7:0]  ow_opc;
    logic [3:0]  ow_tgt_gp, ow_tgt_sr, ow_tgt_ar;
    logic        ow_tgt_gp_we, ow_tgt_sr_we, ow_tgt_ar_we;

    int          n_checks = 0;
    int          n_bad    = 0;
    int          n_txn    = 0;
    logic [23:0] model_mem [0:MEM_WORDS-1];
    txn_t        pend [$];

    amber_mem_ldst #(
        .MEM_WORDS(MEM_WORDS), .OPC_W(8), .TGT_W(4),
        .OPC_NOP(NOP), .OPC_LDur(LDUR), .OPC_LDso(LDSO),
        .OPC_STur(STUR), .OPC_STui(STUI), .OPC_STsi(STSI), .OPC_STso(STSO)
    ) dut (
        .iw_clk(clk), .iw_rst(rst),
        .iw_pc(iw_pc), .iw_instr(iw_instr), .iw_opc(iw_opc), .iw_addr(iw_addr),
        .iw_result(iw_result), .iw_sr_result(iw_sr_result), .iw_ar_result(iw_ar_result),
        .iw_tgt_gp(iw_tgt_gp), .iw_tgt_sr(iw_tgt_sr), .iw_tgt_ar(iw_tgt_ar),
        .iw_tgt_gp_we(iw_tgt_gp_we), .iw_tgt_sr_we(iw_tgt_sr_we), .iw_tgt_ar_we(iw_tgt_ar_we),
        .ow_pc(ow_pc), .ow_instr(ow_instr), .ow_opc(ow_opc), .ow_result(ow_result),
        .ow_sr_result(ow_sr_result), .ow_ar_result(ow_ar_result),
        .ow_tgt_gp(ow_tgt_gp), .ow_tgt_sr(ow_tgt_sr), .ow_tgt_ar(ow_tgt_ar),
        .ow_tgt_gp_we(ow_tgt_gp_we), .ow_tgt_sr_we(ow_tgt_sr_we), .ow_tgt_ar_we(ow_tgt_ar_we)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic txn_t mk(input logic [7:0] opc, input logic [47:0] addr, input logic [23:0] data);
        txn_t t;
        t.pc     = 48'({$urandom(), $urandom()});
        t.instr  = 24'($urandom());
        t.opc    = opc;
        t.addr   = addr;
        t.result = data;
        t.sr     = 48'({$urandom(), $urandom()});
        t.ar     = 48'({$urandom(), $urandom()});
        t.tgp    = 4'($urandom());
        t.tsr    = 4'($urandom());
        t.tar    = 4'($urandom());
        t.we     = 3'($urandom());
        return t;
    endfunction

    task automatic put(input txn_t t);
        iw_pc = t.pc; iw_instr = t.instr; iw_opc = t.opc; iw_addr = t.addr;
        iw_result = t.result; iw_sr_result = t.sr; iw_ar_result = t.ar;
        iw_tgt_gp = t.tgp; iw_tgt_sr = t.tsr; iw_tgt_ar = t.tar;
        {iw_tgt_gp_we, iw_tgt_sr_we, iw_tgt_ar_we} = t.we;
    endtask

    // Present one transaction, update the model in program order, advance one
    // edge, and compare the record that must now be at WB.
    task automatic issue(input txn_t t);
        txn_t e;
        int   idx;
        put(t);
        e   = t;
        idx = int'(t.addr % 48'(MEM_WORDS));
        if (t.opc == LDUR || t.opc == LDSO) e.result = model_mem[idx];
        if (t.opc == STUR || t.opc == STUI || t.opc == STSI || t.opc == STSO) model_mem[idx] = t.result;
        pend.push_back(e);
        step();
        if (pend.size() >= 2) begin
            e = pend.pop_front();
            n_txn++;
            $display("txn %0d opc=%h addr=%h result=%h wb_result=%h", n_txn, e.opc, e.addr, e.result, ow_result);
            check_val("wb_pc",     64'(ow_pc),        64'(e.pc));
            check_val("wb_instr",  64'(ow_instr),     64'(e.instr));
            check_val("wb_opc",    64'(ow_opc),       64'(e.opc));
            check_val("wb_result", 64'(ow_result),    64'(e.result));
            check_val("wb_sr",     64'(ow_sr_result), 64'(e.sr));
            check_val("wb_ar",     64'(ow_ar_result), 64'(e.ar));
            check_val("wb_tgts",   64'({ow_tgt_gp, ow_tgt_sr, ow_tgt_ar, ow_tgt_gp_we, ow_tgt_sr_we, ow_tgt_ar_we}),
                                   64'({e.tgp, e.tsr, e.tar, e.we}));
        end
    endtask

    task automatic preload(input int a, input logic [23:0] v);
        dut.r_mem[a] = v;
        model_mem[a] = v;
    endtask

    task automatic check_mem(input string tag, input int a, input logic [23:0] v);
        check_val(tag, 64'(dut.r_mem[a]), 64'(v));
    endtask

    function automatic logic [7:0] pick_opc(input int unsigned r);
        case (r % 10)
            0: return LDUR;
            1: return LDSO;
            2: return STUR;
            3: return STUI;
            4: return STSI;
            5: return STSO;
            6: return 8'h05;
            7: return 8'h12;
            default: return NOP;
        endcase
    endfunction

    initial begin
        logic [47:0] a;
        rst = 1'b1;
        put(mk(NOP, 48'd0, 24'd0));
        for (int i = 0; i < MEM_WORDS; i++) preload(i, 24'($urandom()));
        repeat (3) step();

        // Reset state at WB
        check_val("rst_pc",     64'(ow_pc), 64'd0);
        check_val("rst_opc",    64'(ow_opc), 64'(NOP));
        check_val("rst_result", 64'(ow_result), 64'd0);
        check_val("rst_misc",   64'({ow_sr_result ^ ow_ar_result, ow_tgt_gp, ow_tgt_sr, ow_tgt_ar,
                                     ow_tgt_gp_we, ow_tgt_sr_we, ow_tgt_ar_we}), 64'd0);
        rst = 1'b0;

        // Plain store
        issue(mk(STUR, 48'd40, 24'hA1B2C3));
        issue(mk(NOP, 48'd0, 24'd0));
        check_mem("stur_mem40", 40, 24'hA1B2C3);

        // Plain load
        preload(50, 24'h00C0DE);
        issue(mk(LDUR, 48'd50, 24'h777777));
        issue(mk(NOP, 48'd0, 24'd0));
        check_val("ldur_result", 64'(ow_result), 64'h00C0DE);
        check_val("ldur_opc",    64'(ow_opc), 64'(LDUR));

        // Immediate / signed stores go in as formed by EX
        issue(mk(STUI, 48'd41, 24'h000123));
        issue(mk(STSI, 48'd42, 24'hFFF800));
        issue(mk(STSO, 48'd60, 24'h112233));
        issue(mk(NOP, 48'd0, 24'd0));
        check_mem("stui_mem41", 41, 24'h000123);
        check_mem("stsi_mem42", 42, 24'hFFF800);
        check_mem("stso_mem60", 60, 24'h112233);

        // LDso, then back-to-back LDso
        preload(61, 24'hABCD01);
        issue(mk(LDSO, 48'd61, 24'd0));
        issue(mk(LDSO, 48'd61, 24'd0));
        check_val("ldso_first", 64'(ow_result), 64'hABCD01);
        issue(mk(NOP, 48'd0, 24'd0));
        check_val("ldso_hold", 64'(ow_result), 64'hABCD01);

        // Store then load to the same address; neighbour unaffected
        preload(71, 24'h555AAA);
        issue(mk(STUR, 48'd70, 24'h3C5A96));
        issue(mk(LDUR, 48'd70, 24'd0));
        issue(mk(LDUR, 48'd71, 24'd0));
        check_val("st_ld_fwd", 64'(ow_result), 64'h3C5A96);
        issue(mk(NOP, 48'd0, 24'd0));
        check_val("ld_other", 64'(ow_result), 64'h555AAA);

        // Address wraps modulo MEM_WORDS
        issue(mk(STUR, 48'hABCD_0000_005A, 24'h0F0F0F));
        issue(mk(NOP, 48'd0, 24'd0));
        check_mem("wrap_mem90", 90, 24'h0F0F0F);

        // Randomized stream over a small, collision-heavy address window
        for (int i = 0; i < 300; i++) begin
            a = 48'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) a = a | (48'($urandom()) << 12);
            issue(mk(pick_opc($urandom()), a, 24'($urandom())));
        end
        issue(mk(NOP, 48'd0, 24'd0));
        issue(mk(NOP, 48'd0, 24'd0));
        for (int i = 0; i < 16; i++) check_mem("rand_mem", i, model_mem[i]);
        pend.delete();

        // Reset arriving on the write edge of an in-flight store
        preload(80, 24'h13579B);
        put(mk(STUR, 48'd80, 24'hDEAD01));
        step();
        rst = 1'b1;
        put(mk(NOP, 48'd0, 24'd0));
        step();
        check_mem("rst_drop_mem80", 80, 24'h13579B);
        check_val("rst2_opc",    64'(ow_opc), 64'(NOP));
        check_val("rst2_result", 64'(ow_result), 64'd0);
        check_val("rst2_all",    64'({ow_pc, ow_instr} ^ {ow_sr_result, 24'd0} ^ {ow_ar_result, 24'd0}) |
                                 64'({ow_tgt_gp, ow_tgt_sr, ow_tgt_ar, ow_tgt_gp_we, ow_tgt_sr_we, ow_tgt_ar_we}),
                                 64'd0);
        rst = 1'b0;
        step();
        check_mem("rst_drop_after", 80, 24'h13579B);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
